// File: rtl/ph_byte_feeder_if.sv
// rtl/ph_byte_feeder_if.sv - parasite-side byte feeder bus bundle
// Purpose: groups the core push port and the downstream byte-buffer port.
// Signals:
//   p_wr_data[7:0]  byte offered by the parasite core
//   p_wr_en         push request
//   p_wr_ready      feeder can accept a push (count < 4)
//   p_full          downstream buffer full flag
//   p_data[7:0]     byte driven to the downstream buffer
//   p_selectData    write-select to the downstream buffer
//   p_rdnw          read/not-write to the downstream buffer
//   p_level[2:0]    FIFO occupancy 0..4
//   p_ovf           sticky overflow flag
// Modports: master = feeder, slave = core/buffer environment.
interface ph_byte_feeder_if;
    logic [7:0] p_wr_data;
    logic       p_wr_en;
    logic       p_wr_ready;
    logic       p_full;
    logic [7:0] p_data;
    logic       p_selectData;
    logic       p_rdnw;
    logic [2:0] p_level;
    logic       p_ovf;

    modport master (
        input  p_wr_data, p_wr_en, p_full,
        output p_wr_ready, p_data, p_selectData, p_rdnw, p_level, p_ovf
    );

    modport slave (
        output p_wr_data, p_wr_en, p_full,
        input  p_wr_ready, p_data, p_selectData, p_rdnw, p_level, p_ovf
    );
endinterface

// File: rtl/ph_byte_feeder.sv
// rtl/ph_byte_feeder.sv - 4-deep byte FIFO feeding the parasite-to-host buffer
// Purpose: queues bytes from the parasite core and writes them one at a time
//          into the downstream buffer with a select strobe and ack wait.
// Ports:
//   p_phi2   clock, rising-edge state updates
//   h_rst_b  asynchronous active-low reset
//   bus      ph_byte_feeder_if.master (push port, buffer port, status)
// Option: define PH_BYTE_FEEDER_OVF_EN to build the sticky overflow flag;
//         otherwise p_ovf is tied low.
module ph_byte_feeder (
    input  logic                   p_phi2,
    input  logic                   h_rst_b,
    ph_byte_feeder_if.master       bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] fifo_q [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic [3:0] tmo_q;
    logic [7:0] data_q;
    logic       sel_q;
    logic       rdnw_q;
    logic       push_ok;
    logic       pop;

    // A full FIFO drops the push even when a pop frees a slot on the same edge.
    always_comb begin
        push_ok  = bus.p_wr_en && (count_q < 3'd4);
        pop      = (state_q == ST_STROBE);
        wr_ptr_d = push_ok ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d  = count_q + {2'b00, push_ok} - {2'b00, pop};
    end

    always_ff @(posedge p_phi2) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= bus.p_wr_data;
        end
    end

    always_ff @(posedge p_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Strobe sequencer: the byte is popped as STROBE is left, so only one
    // write is ever in flight and the ACK wait gates the next one.
    always_ff @(posedge p_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            state_q <= ST_IDLE;
            tmo_q   <= 4'd0;
            data_q  <= 8'h00;
            sel_q   <= 1'b0;
            rdnw_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if ((count_q != 3'd0) && !bus.p_full) begin
                        data_q  <= fifo_q[rd_ptr_q];
                        sel_q   <= 1'b1;
                        rdnw_q  <= 1'b0;
                        state_q <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    sel_q   <= 1'b0;
                    rdnw_q  <= 1'b1;
                    tmo_q   <= 4'd0;
                    state_q <= ST_ACK;
                end
                ST_ACK: begin
                    // Give up after 16 cycles so a buffer that never reports
                    // full cannot stall the feeder forever.
                    if (bus.p_full || (tmo_q == 4'hF)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PH_BYTE_FEEDER_OVF_EN
    logic ovf_q;

    always_ff @(posedge p_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            ovf_q <= 1'b0;
        end else if (bus.p_wr_en && !push_ok) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.p_ovf = ovf_q;
`else
    assign bus.p_ovf = 1'b0;
`endif

    assign bus.p_data       = data_q;
    assign bus.p_selectData = sel_q;
    assign bus.p_rdnw       = rdnw_q;
    assign bus.p_level      = count_q;
    assign bus.p_wr_ready   = (count_q < 3'd4);

endmodule

// File: tb/tb_ph_byte_feeder.sv
// tb/tb_ph_byte_feeder.sv - self-checking bench for ph_byte_feeder
module tb_ph_byte_feeder;

`ifdef PH_BYTE_FEEDER_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic p_phi2  = 1'b0;
    logic h_rst_b = 1'b0;

    ph_byte_feeder_if bus_if ();

    ph_byte_feeder dut (
        .p_phi2  (p_phi2),
        .h_rst_b (h_rst_b),
        .bus     (bus_if)
    );

    always #5 p_phi2 = ~p_phi2;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the write-cycle phase as seen
    // from the downstream buffer (0 idle, 1 strobe, 2 awaiting ack).
    logic [7:0] m_q [$];
    logic [7:0] m_data;
    logic       m_sel;
    logic       m_rdnw;
    logic       m_ovf;
    int         m_phase;
    int         m_ack_n;

    always @(posedge p_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            m_q.delete();
            m_data  = 8'h00;
            m_sel   = 1'b0;
            m_rdnw  = 1'b1;
            m_ovf   = 1'b0;
            m_phase = 0;
            m_ack_n = 0;
        end else begin
            int n;
            bit take;
            n    = m_q.size();
            take = bus_if.p_wr_en && (n < 4);
            if (bus_if.p_wr_en && (n == 4) && OVF_EN) m_ovf = 1'b1;
            case (m_phase)
                0: if (n > 0 && !bus_if.p_full) begin
                    m_data  = m_q[0];
                    m_sel   = 1'b1;
                    m_rdnw  = 1'b0;
                    m_phase = 1;
                end
                1: begin
                    void'(m_q.pop_front());
                    m_sel   = 1'b0;
                    m_rdnw  = 1'b1;
                    m_phase = 2;
                    m_ack_n = 0;
                end
                default: begin
                    if (bus_if.p_full || m_ack_n == 15) m_phase = 0;
                    else m_ack_n++;
                end
            endcase
            if (take) m_q.push_back(bus_if.p_wr_data);
        end
    end

    always @(negedge p_phi2) begin
        if (h_rst_b) begin
            check("cyc_p_data",       {24'd0, bus_if.p_data},       {24'd0, m_data});
            check("cyc_p_selectData", {31'd0, bus_if.p_selectData}, {31'd0, m_sel});
            check("cyc_p_rdnw",       {31'd0, bus_if.p_rdnw},       {31'd0, m_rdnw});
            check("cyc_p_level",      {29'd0, bus_if.p_level},      m_q.size());
            check("cyc_p_wr_ready",   {31'd0, bus_if.p_wr_ready},   {31'd0, (m_q.size() < 4)});
            check("cyc_p_ovf",        {31'd0, bus_if.p_ovf},        {31'd0, m_ovf});
        end
    end

    task automatic push(input logic [7:0] b);
        bus_if.p_wr_data = b;
        bus_if.p_wr_en   = 1'b1;
        @(negedge p_phi2);
        bus_if.p_wr_en   = 1'b0;
    endtask

    task automatic wait_sel(output bit ok, output int cycles);
        ok     = 1'b0;
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge p_phi2);
            cycles = i + 1;
            if (bus_if.p_selectData === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Host side: release full, catch the strobe, then ack with full.
    task automatic host_read(output logic [7:0] b);
        bit ok;
        int cyc;
        bus_if.p_full = 1'b0;
        wait_sel(ok, cyc);
        check("strobe_seen", {31'd0, ok}, 32'd1);
        b = bus_if.p_data;
        @(negedge p_phi2);
        check("strobe_width", {31'd0, bus_if.p_selectData}, 32'd0);
        bus_if.p_full = 1'b1;
        @(negedge p_phi2);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] exp_bytes [4];
        bit ok;
        int cyc;
        int highs;

        bus_if.p_wr_data = 8'h00;
        bus_if.p_wr_en   = 1'b0;
        bus_if.p_full    = 1'b0;

        repeat (3) @(negedge p_phi2);
        check("rst_level",    {29'd0, bus_if.p_level},      32'd0);
        check("rst_ready",    {31'd0, bus_if.p_wr_ready},   32'd1);
        check("rst_sel",      {31'd0, bus_if.p_selectData}, 32'd0);
        check("rst_rdnw",     {31'd0, bus_if.p_rdnw},       32'd1);
        check("rst_data",     {24'd0, bus_if.p_data},       32'h00);
        check("rst_ovf",      {31'd0, bus_if.p_ovf},        32'd0);
        h_rst_b = 1'b1;
        @(negedge p_phi2);

        // Single byte with the buffer empty.
        push(8'h5A);
        wait_sel(ok, cyc);
        check("t1_strobe_seen", {31'd0, ok}, 32'd1);
        check("t1_latency",     cyc,  32'd1);
        check("t1_data",        {24'd0, bus_if.p_data}, 32'h5A);
        check("t1_rdnw",        {31'd0, bus_if.p_rdnw}, 32'd0);
        @(negedge p_phi2);
        check("t1_width",       {31'd0, bus_if.p_selectData}, 32'd0);
        bus_if.p_full = 1'b1;
        @(negedge p_phi2);
        check("t1_level",       {29'd0, bus_if.p_level}, 32'd0);

        // Fill while the buffer is full; fifth push is discarded.
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        push(8'h05);
        check("t2_level", {29'd0, bus_if.p_level},      32'd4);
        check("t2_ready", {31'd0, bus_if.p_wr_ready},   32'd0);
        check("t2_sel",   {31'd0, bus_if.p_selectData}, 32'd0);
        check("t2_ovf",   {31'd0, bus_if.p_ovf},        {31'd0, OVF_EN});

        // Drain in order across the pointer wrap.
        exp_bytes[0] = 8'h01;
        exp_bytes[1] = 8'h02;
        exp_bytes[2] = 8'h03;
        exp_bytes[3] = 8'h04;
        for (int i = 0; i < 4; i++) begin
            host_read(b);
            check($sformatf("t3_byte%0d", i), {24'd0, b}, {24'd0, exp_bytes[i]});
        end
        check("t3_level", {29'd0, bus_if.p_level}, 32'd0);

        // Push and pop on the same edge at level 2.
        push(8'hAA);
        push(8'hBB);
        check("t4_level_pre", {29'd0, bus_if.p_level}, 32'd2);
        bus_if.p_full = 1'b0;
        wait_sel(ok, cyc);
        check("t4_byte0", {24'd0, bus_if.p_data}, 32'hAA);
        push(8'hCC);
        check("t4_level_same_edge", {29'd0, bus_if.p_level}, 32'd2);
        bus_if.p_full = 1'b1;
        @(negedge p_phi2);
        host_read(b);
        check("t4_byte1", {24'd0, b}, 32'hBB);
        host_read(b);
        check("t4_byte2", {24'd0, b}, 32'hCC);

        // Ack timeout with the buffer never reporting full.
        push(8'h77);
        push(8'h88);
        bus_if.p_full = 1'b0;
        wait_sel(ok, cyc);
        check("t5_byte0", {24'd0, bus_if.p_data}, 32'h77);
        wait_sel(ok, cyc);
        check("t5_seen",  {31'd0, ok}, 32'd1);
        check("t5_gap",   cyc, 32'd18);
        check("t5_byte1", {24'd0, bus_if.p_data}, 32'h88);
        @(negedge p_phi2);
        bus_if.p_full = 1'b1;
        @(negedge p_phi2);
        check("t5_level", {29'd0, bus_if.p_level}, 32'd0);

        // Reset in the middle of a strobe.
        push(8'h33);
        bus_if.p_full = 1'b0;
        wait_sel(ok, cyc);
        check("t6_strobe_seen", {31'd0, ok}, 32'd1);
        #2;
        h_rst_b = 1'b0;
        #1;
        check("t6_sel",   {31'd0, bus_if.p_selectData}, 32'd0);
        check("t6_rdnw",  {31'd0, bus_if.p_rdnw},       32'd1);
        check("t6_level", {29'd0, bus_if.p_level},      32'd0);
        check("t6_data",  {24'd0, bus_if.p_data},       32'h00);
        check("t6_ready", {31'd0, bus_if.p_wr_ready},   32'd1);
        check("t6_ovf",   {31'd0, bus_if.p_ovf},        32'd0);
        @(negedge p_phi2);
        h_rst_b = 1'b1;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge p_phi2);
            if (bus_if.p_selectData === 1'b1) highs++;
        end
        check("t6_no_strobe", highs, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ph_byte_feeder.md
PH_BYTE_FEEDER -- requirements
Module: ph_byte_feeder

Interface
REQ-001 SHALL have ports: p_phi2  input  1  parasite clock; all state updates on its rising edge.
REQ-002 SHALL have ports: h_rst_b  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: p_wr_data  input  8  byte offered by the parasite core.
REQ-004 SHALL have ports: p_wr_en  input  1  push request, sampled on the p_phi2 rising edge.
REQ-005 SHALL have ports: p_full  input  1  full flag from the downstream parasite-to-host byte buffer.
REQ-006 SHALL have ports: p_wr_ready  output  1  high when count < 4.
REQ-007 SHALL have ports: p_data  output  8  registered byte driven to the downstream buffer.
REQ-008 SHALL have ports: p_selectData  output  1  registered write-select to the downstream buffer.
REQ-009 SHALL have ports: p_rdnw  output  1  registered read/not-write to the downstream buffer.
REQ-010 SHALL have ports: p_level  output  3  current FIFO occupancy, 0..4.
REQ-011 SHALL have ports: p_ovf  output  1  sticky overflow flag (see Configuration).

Function
REQ-012 SHALL hold a 4-entry x 8-bit FIFO with 2-bit read/write pointers (wrap 3->0) and a 3-bit count.
REQ-013 SHALL accept a push on an edge with p_wr_en=1 and count<4, write at wr_ptr, increment wr_ptr.
REQ-014 SHALL discard a push with count==4, even if a pop occurs on the same edge; FIFO contents unchanged.
REQ-015 SHALL on a simultaneous accepted push and pop keep count unchanged and advance both pointers.
REQ-016 SHALL implement FSM states IDLE, STROBE and ACK.
REQ-017 SHALL in IDLE, with count>0 and p_full=0, load p_data<=fifo[rd_ptr], set p_selectData<=1 and p_rdnw<=0, and go to STROBE.
REQ-018 SHALL hold STROBE for exactly one p_phi2 cycle; on the edge that leaves STROBE: pop (rd_ptr+1, count-1), p_selectData<=0, p_rdnw<=1, go to ACK.
REQ-019 SHALL in ACK wait for p_full=1, then go to IDLE; a 4-bit timeout counter SHALL force IDLE after 16 ACK cycles without p_full.
REQ-020 SHALL hold p_data unchanged outside the IDLE->STROBE load.
REQ-021 SHALL never have more than one STROBE outstanding; back-to-back bytes are separated by at least ACK plus one IDLE cycle.
REQ-022 SHALL not start a STROBE while p_full=1; IDLE holds until the host drains the downstream buffer.
REQ-023 SHALL drive p_level equal to count and p_wr_ready = (count<4), both derived from registered state.

Reset
REQ-024 SHALL on h_rst_b=0 immediately force: state IDLE, pointers 0, count 0, timeout 0, p_data 8'h00, p_selectData 0, p_rdnw 1, p_ovf 0; hence p_level 0 and p_wr_ready 1.
REQ-025 SHALL abandon a STROBE or ACK in progress when reset asserts; the FIFO byte is lost and no further strobe occurs.

Configuration
REQ-026 SHALL, with macro PH_BYTE_FEEDER_OVF_EN defined, set p_ovf on any discarded push and hold it until reset.
REQ-027 SHALL, without PH_BYTE_FEEDER_OVF_EN, tie p_ovf to 0 and include no overflow register; discard behaviour is unchanged.

Verification
REQ-028 SHALL cover: reset, push 0x5A with p_full=0 -> p_selectData=1, p_rdnw=0, p_data=0x5A for exactly one cycle, 2 edges after push; p_level returns to 0.
REQ-029 SHALL cover: push 0x01..0x04 on consecutive edges with p_full held 1 -> no strobe, p_level=4, p_wr_ready=0; fifth push 0x05 is discarded; p_ovf=1 only with PH_BYTE_FEEDER_OVF_EN.
REQ-030 SHALL cover: with 4 bytes queued, toggle p_full low/high per host read -> bytes emerge in order 0x01,0x02,0x03,0x04 with pointer wrap exercised.
REQ-031 SHALL cover: push and pop on the same edge at count=2 -> p_level stays 2 and byte order is preserved.
REQ-032 SHALL cover: p_full stuck 0 after a strobe -> ACK timeout returns to IDLE after 16 cycles, then the next byte strobes.
REQ-033 SHALL cover: h_rst_b pulsed low during STROBE -> p_selectData=0 and p_rdnw=1 asynchronously; p_level=0; no strobe after release.
